wb_port_arbiter: RTL and testbench

Shares the single register-file write port among N_SRC writeback producers (src 0 = ALU pipe, 1 = load pipe, 2 = multi-cycle mul/div) using round-robin arbitration with valid/ready handshakes. It drives a registered write-enable/address/data triple into the register file, placed where the writeback stage feeds the RF write port. It also keeps a 32-entry pending-write scoreboard: decode marks a destination busy on issue, and the arbiter clears it when the write commits. Decode uses the scoreboard for slot-filling and stall decisions.

---
 rtl/wb_port_arbiter.sv | 113 +++++++++++
 tb/tb_wb_port_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Round-robin writeback arbiter for the single RF write port,
// with a pending-write scoreboard consulted by decode.
module wb_port_arbiter #(
    parameter int N_SRC = 3,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_SRC-1:0]      src_valid,
    output logic [N_SRC-1:0]      src_ready,
    input  logic [N_SRC*AW-1:0]   src_addr,
    input  logic [N_SRC*DW-1:0]   src_data,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rd,
    input  logic [AW-1:0]         q_rs1,
    input  logic [AW-1:0]         q_rs2,
    output logic                  q_rs1_busy,
    output logic                  q_rs2_busy,
    output logic                  wb_we,
    output logic [AW-1:0]         wb_addr,
    output logic [DW-1:0]         wb_data,
    output logic [(1<<AW)-1:0]    busy_vec
);

    localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int NR = 1 << AW;

    logic [PW-1:0] last_q, last_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [NR-1:0] busy_q, busy_d;

    logic [AW-1:0] addr_a [N_SRC];
    logic [DW-1:0] data_a [N_SRC];
    logic [PW-1:0] cand [N_SRC];
    logic [PW-1:0] gnt_idx;
    logic          fire;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_data;

    for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
        assign addr_a[i] = src_addr[i*AW +: AW];
        assign data_a[i] = src_data[i*DW +: DW];
    end

    // Search order starts just after the last winner and wraps.
    always_comb begin
        for (int k = 0; k < N_SRC; k++) begin
            cand[k] = PW'((int'(last_q) + k + 1) % N_SRC);
        end
    end

    always_comb begin
        src_ready = '0;
        gnt_idx   = last_q;
        fire      = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (!fire && src_valid[cand[k]]) begin
                fire               = 1'b1;
                gnt_idx            = cand[k];
                src_ready[cand[k]] = 1'b1;
            end
        end
    end

    assign g_addr = addr_a[gnt_idx];
    assign g_data = data_a[gnt_idx];

    always_comb begin
        last_d = fire ? gnt_idx : last_q;
        we_d   = fire && (g_addr != '0);
        addr_d = fire ? g_addr : addr_q;
        data_d = fire ? g_data : data_q;
    end

    // Set after clear so a same-cycle reissue keeps the register pending.
    always_comb begin
        busy_d = busy_q;
        if (we_q) begin
            busy_d[addr_q] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= PW'(N_SRC - 1);
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            busy_q <= '0;
        end else begin
            last_q <= last_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    assign wb_we      = we_q;
    assign wb_addr    = addr_q;
    assign wb_data    = data_q;
    assign busy_vec   = busy_q;
    assign q_rs1_busy = busy_q[q_rs1];
    assign q_rs2_busy = busy_q[q_rs2];

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Vector-table bench for wb_port_arbiter with a queue of
// expected RF writes checked one cycle after each grant.
module tb_wb_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NV = 30;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    src_valid;
    logic [N-1:0]    src_ready;
    logic [N*AW-1:0] src_addr;
    logic [N*DW-1:0] src_data;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic [AW-1:0]   q_rs1;
    logic [AW-1:0]   q_rs2;
    logic            q_rs1_busy;
    logic            q_rs2_busy;
    logic            wb_we;
    logic [AW-1:0]   wb_addr;
    logic [DW-1:0]   wb_data;
    logic [31:0]     busy_vec;

    always #5 clk = ~clk;

    wb_port_arbiter #(.N_SRC(N), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_addr   (src_addr),
        .src_data   (src_data),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .q_rs1      (q_rs1),
        .q_rs2      (q_rs2),
        .q_rs1_busy (q_rs1_busy),
        .q_rs2_busy (q_rs2_busy),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .busy_vec   (busy_vec)
    );

    typedef struct {
        logic            rst;
        logic [N-1:0]    v;
        logic [N*AW-1:0] a;
        logic [N*DW-1:0] d;
        logic            iv;
        logic [AW-1:0]   ird;
        logic [AW-1:0]   q1;
        logic [AW-1:0]   q2;
        logic [N-1:0]    rdy;
        logic [31:0]     busy;
    } vec_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wb_t;

    vec_t vt [NV];
    wb_t  exp_q [$];
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(
        input int r, input int v,
        input int a0, input int a1, input int a2,
        input logic [31:0] d0, input logic [31:0] d1,
        input logic [31:0] d2,
        input int iv, input int ird,
        input int q1, input int q2,
        input int rdy, input logic [31:0] busy);
        vec_t t;
        t.rst  = 1'(r);
        t.v    = N'(v);
        t.a    = {AW'(a2), AW'(a1), AW'(a0)};
        t.d    = {d2, d1, d0};
        t.iv   = 1'(iv);
        t.ird  = AW'(ird);
        t.q1   = AW'(q1);
        t.q2   = AW'(q2);
        t.rdy  = N'(rdy);
        t.busy = busy;
        return t;
    endfunction

    task automatic chk(input string nm, input int i,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %0h want %0h",
                     nm, i, act, exp);
        end
    endtask

    task automatic check_wb(input int i);
        wb_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wb_queue vec %0d: got empty want entry", i);
        end else begin
            e = exp_q.pop_front();
            chk("wb_we", i, 32'(wb_we), 32'(e.we));
            chk("wb_addr", i, 32'(wb_addr), 32'(e.a));
            chk("wb_data", i, wb_data, e.d);
        end
    endtask

    initial begin
        wb_t           e;
        logic [AW-1:0] hold_a;
        logic [DW-1:0] hold_d;

        rst_n     = 1'b0;
        src_valid = '0;
        src_addr  = '0;
        src_data  = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        q_rs1     = '0;
        q_rs2     = '0;
        hold_a    = '0;
        hold_d    = '0;

        //            r v   a0 a1 a2 d0     d1           d2    iv rd q1 q2 rdy busy
        vt[0]  = mk(0, 0,  0, 0, 0, 0,     0,           0,     0, 0, 0, 0, 0, 0);
        vt[1]  = mk(1, 7,  1, 2, 3, 'hA1, 'hA2,         'hA3,  0, 0, 1, 0, 1, 0);
        vt[2]  = mk(1, 7,  1, 2, 3, 'hA1, 'hA2,         'hA3,  0, 0, 1, 0, 2, 0);
        vt[3]  = mk(1, 7,  1, 2, 3, 'hA1, 'hA2,         'hA3,  0, 0, 1, 0, 4, 0);
        vt[4]  = mk(1, 7,  1, 2, 3, 'hA1, 'hA2,         'hA3,  0, 0, 1, 0, 1, 0);
        vt[5]  = mk(1, 7,  1, 2, 3, 'hA1, 'hA2,         'hA3,  0, 0, 1, 0, 2, 0);
        vt[6]  = mk(1, 7,  1, 2, 3, 'hA1, 'hA2,         'hA3,  0, 0, 1, 0, 4, 0);
        vt[7]  = mk(1, 2,  0, 7, 0, 0,     'hDEADBEEF,  0,     0, 0, 7, 0, 2, 0);
        vt[8]  = mk(1, 2,  0, 7, 0, 0,     'hDEADBEEF,  0,     0, 0, 7, 0, 2, 0);
        vt[9]  = mk(1, 2,  0, 7, 0, 0,     'hDEADBEEF,  0,     0, 0, 7, 0, 2, 0);
        vt[10] = mk(1, 2,  0, 7, 0, 0,     'hDEADBEEF,  0,     0, 0, 7, 0, 2, 0);
        vt[11] = mk(1, 0,  0, 0, 0, 0,     0,           0,     1, 5, 5, 0, 0, 0);
        vt[12] = mk(1, 0,  0, 0, 0, 0,     0,           0,     0, 0, 5, 0, 0, 'h20);
        vt[13] = mk(1, 0,  0, 0, 0, 0,     0,           0,     0, 0, 5, 0, 0, 'h20);
        vt[14] = mk(1, 4,  0, 0, 5, 0,     0,           'h55,  0, 0, 5, 0, 4, 'h20);
        vt[15] = mk(1, 0,  0, 0, 0, 0,     0,           0,     0, 0, 5, 0, 0, 'h20);
        vt[16] = mk(1, 0,  0, 0, 0, 0,     0,           0,     0, 0, 5, 0, 0, 0);
        vt[17] = mk(1, 0,  0, 0, 0, 0,     0,           0,     1, 9, 9, 0, 0, 0);
        vt[18] = mk(1, 1,  9, 0, 0, 'h99, 0,           0,     0, 0, 9, 0, 1, 'h200);
        vt[19] = mk(1, 0,  0, 0, 0, 0,     0,           0,     1, 9, 9, 0, 0, 'h200);
        vt[20] = mk(1, 2,  0, 9, 0, 0,     'h98,        0,     0, 0, 9, 0, 2, 'h200);
        vt[21] = mk(1, 0,  0, 0, 0, 0,     0,           0,     1, 10, 9, 10, 0, 'h200);
        vt[22] = mk(1, 0,  0, 0, 0, 0,     0,           0,     0, 0, 9, 10, 0, 'h400);
        vt[23] = mk(1, 1,  0, 0, 0, 'h1234, 0,          0,     1, 0, 0, 10, 1, 'h400);
        vt[24] = mk(1, 3, 11, 12, 0, 'hB0, 'hB1,        0,     0, 0, 0, 10, 2, 'h400);
        vt[25] = mk(1, 3, 11, 12, 0, 'hB0, 'hB1,        0,     0, 0, 0, 10, 1, 'h400);
        vt[26] = mk(0, 6,  0, 13, 14, 0,   'hC1,        'hC2,  0, 0, 10, 0, 2, 'h400);
        vt[27] = mk(1, 6,  0, 13, 14, 0,   'hC1,        'hC2,  0, 0, 10, 0, 2, 0);
        vt[28] = mk(1, 6,  0, 13, 14, 0,   'hC1,        'hC2,  0, 0, 10, 0, 4, 0);
        vt[29] = mk(1, 0,  0, 0, 0, 0,     0,           0,     0, 0, 0, 0, 0, 0);

        e.we = 1'b0;
        e.a  = '0;
        e.d  = '0;
        exp_q.push_back(e);

        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            #1;
            rst_n     = vt[i].rst;
            src_valid = vt[i].v;
            src_addr  = vt[i].a;
            src_data  = vt[i].d;
            iss_valid = vt[i].iv;
            iss_rd    = vt[i].ird;
            q_rs1     = vt[i].q1;
            q_rs2     = vt[i].q2;
            #3;
            chk("src_ready", i, 32'(src_ready), 32'(vt[i].rdy));
            chk("busy_vec", i, busy_vec, vt[i].busy);
            chk("q_rs1_busy", i, 32'(q_rs1_busy),
                32'(vt[i].busy[vt[i].q1]));
            chk("q_rs2_busy", i, 32'(q_rs2_busy),
                32'(vt[i].busy[vt[i].q2]));
            check_wb(i);

            if (!vt[i].rst) begin
                e.we   = 1'b0;
                e.a    = '0;
                e.d    = '0;
                hold_a = '0;
                hold_d = '0;
            end else if (vt[i].rdy != '0) begin
                e.we = 1'b0;
                for (int j = 0; j < N; j++) begin
                    if (vt[i].rdy[j]) begin
                        e.a  = vt[i].a[j*AW +: AW];
                        e.d  = vt[i].d[j*DW +: DW];
                        e.we = (e.a != '0);
                    end
                end
                hold_a = e.a;
                hold_d = e.d;
            end else begin
                e.we = 1'b0;
                e.a  = hold_a;
                e.d  = hold_d;
            end
            exp_q.push_back(e);
            n_vec++;
            @(posedge clk);
        end

        #4;
        check_wb(NV);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
